// File: rtl/ram_w_pkg.sv
// Shared types and build-time defaults for the weight-RAM read path.
package ram_w_pkg;

    localparam int DEF_ADDR_SIZE  = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MEM_LENGTH = 16;

    localparam int RD_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } rd_state_e;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry data+last FIFO sitting between a 1-cycle-latency RAM and a
// valid/ready consumer; simultaneous push and pop are both honoured.
module rd_skid_fifo
    import ram_w_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic                  head_valid_o,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  head_last_o,
    output logic [1:0]            occ_o
);

    logic [DATA_WIDTH-1:0] data_q [RD_BUF_DEPTH];
    logic                  last_q [RD_BUF_DEPTH];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            occ_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the storage is only two entries and is cleared so the head word reads zero out of reset.
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q] <= push_data_i;
                last_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign head_valid_o = (occ_q != '0);
    assign head_data_o  = data_q[rd_ptr_q];
    assign head_last_o  = last_q[rd_ptr_q];
    assign occ_o        = occ_q;

endmodule

// File: rtl/ram_w_reader.sv
// Read-side initiator for the single-port weight RAM: turns a base/length
// command into a read burst and delivers the words as a valid/ready stream.
module ram_w_reader
    import ram_w_pkg::*;
#(
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_LENGTH = DEF_MEM_LENGTH,
    parameter int LEN_SIZE   = ADDR_SIZE + 1
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_SIZE-1:0]  base_addr,
    input  logic [LEN_SIZE-1:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_SIZE-1:0]  ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    input  logic [DATA_WIDTH-1:0] ram_douta,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_last
);

    rd_state_e            state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [LEN_SIZE-1:0]  len_q, len_d;
    logic [LEN_SIZE-1:0]  issued_q, issued_d;
    logic                 done_q, done_d;
    logic                 pending_q;
    logic                 pend_last_q;

    logic [1:0]           occ;
    logic                 head_last;
    logic                 pop;
    logic [2:0]           fill;
    logic                 final_issue;

    // Words already buffered or in flight from the RAM must leave room for one more.
    assign pop         = w_valid & w_ready;
    assign fill        = 3'(occ) + 3'(pending_q) - 3'(pop);
    assign ram_ena     = (state_q == FETCH) && (issued_q < len_q) && (fill < 3'(RD_BUF_DEPTH));
    assign final_issue = ram_ena && (issued_q == len_q - LEN_SIZE'(1));

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned.
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d   = base_addr;
                        len_d    = len;
                        issued_d = '0;
                        state_d  = FETCH;
                    end
                end
            end
            FETCH: begin
                if (final_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && w_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ram_ena) begin
            issued_d = issued_q + LEN_SIZE'(1);
            addr_d   = (addr_q == ADDR_SIZE'(MEM_LENGTH - 1)) ? '0 : addr_q + ADDR_SIZE'(1);
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            done_q      <= 1'b0;
            pending_q   <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            done_q      <= done_d;
            pending_q   <= ram_ena;
            pend_last_q <= final_issue;
        end
    end

    rd_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i        (clka),
        .rst_i        (rst),
        .push_i       (pending_q),
        .push_data_i  (ram_douta),
        .push_last_i  (pend_last_q),
        .pop_i        (pop),
        .head_valid_o (w_valid),
        .head_data_o  (w_data),
        .head_last_o  (head_last),
        .occ_o        (occ)
    );

    assign w_last    = w_valid & head_last;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign ram_addra = addr_q;
    assign ram_wea   = 1'b0;
    assign ram_dina  = '0;

endmodule

// File: tb/tb_ram_w_reader.sv
// Directed bench for ram_w_reader with a behavioural 1-cycle-latency RAM.
module tb_ram_w_reader;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int MEM = 16;
    localparam int LW  = AW + 1;

    logic          clka = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          ram_ena;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina;
    logic [DW-1:0] ram_douta = '0;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic          w_last;

    logic [DW-1:0] mem [MEM];

    int checks = 0;
    int errors = 0;

    always #5 clka = ~clka;

    always @(posedge clka) begin
        if (ram_ena) ram_douta <= mem[ram_addra];
    end

    ram_w_reader #(
        .ADDR_SIZE  (AW),
        .DATA_WIDTH (DW),
        .MEM_LENGTH (MEM),
        .LEN_SIZE   (LW)
    ) dut (
        .clka      (clka),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_douta (ram_douta),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_last    (w_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},    busy,      0);
        chk({tag, "_done"},    done,      0);
        chk({tag, "_ena"},     ram_ena,   0);
        chk({tag, "_addr"},    ram_addra, 0);
        chk({tag, "_wvalid"},  w_valid,   0);
        chk({tag, "_wlast"},   w_last,    0);
        chk({tag, "_wdata"},   w_data,    0);
    endtask

    // mode 0: w_ready held high; mode 1: w_ready follows 1,0,0 repeating.
    // inject: a second start (base 7, len 3) is raised in cycle 4 of the burst.
    task automatic run_burst(input int b, input int n, input int mode, input bit inject);
        int            issued    = 0;
        int            popped    = 0;
        int            first_pop = -1;
        int            last_pop  = -1;
        bit            finished  = 0;
        bit            hold      = 0;
        logic [DW-1:0] hold_data = '0;
        logic          hold_last = 1'b0;

        start     = 1'b1;
        base_addr = AW'(b);
        len       = LW'(n);
        w_ready   = 1'b1;
        @(posedge clka); #1;
        start = 1'b0;

        for (int c = 1; c <= 80 && !finished; c++) begin
            w_ready = (mode == 0) ? 1'b1 : ((c - 1) % 3 == 0);
            if (inject) begin
                start     = (c == 4);
                base_addr = AW'(7);
                len       = LW'(3);
            end
            #1;
            if (c == 1 && n != 0) chk("busy_set", busy, 1);
            if (hold) begin
                chk("stable_valid", w_valid, 1);
                chk("stable_data",  w_data,  hold_data);
                chk("stable_last",  w_last,  hold_last);
            end
            hold      = w_valid && !w_ready;
            hold_data = w_data;
            hold_last = w_last;
            if (ram_ena) begin
                chk("issue_addr", ram_addra, (b + issued) % MEM);
                chk("issue_room", (issued - popped - int'(w_valid && w_ready)) < 2, 1);
                issued++;
            end
            if (w_valid && w_ready) begin
                chk("word_data", w_data, mem[(b + popped) % MEM]);
                chk("word_last", w_last, popped == n - 1);
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                popped++;
            end
            if (done) begin
                chk("done_busy",    busy,   0);
                chk("done_words",   popped, n);
                chk("done_issued",  issued, n);
                if (n == 0) begin
                    chk("done_latency_len0", c, 1);
                end else begin
                    chk("done_after_last", c, last_pop + 1);
                end
                if (mode == 0 && n != 0) begin
                    chk("first_word_cycle", first_pop, 3);
                    chk("back_to_back",     last_pop,  first_pop + n - 1);
                end
                finished = 1;
            end
            @(posedge clka); #1;
        end
        start = 1'b0;
        if (!finished) chk("burst_timeout", 0, 1);

        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_done",   done,    0);
            chk("idle_busy",   busy,    0);
            chk("idle_ena",    ram_ena, 0);
            chk("idle_wvalid", w_valid, 0);
            @(posedge clka); #1;
        end
    endtask

    initial begin
        int pops = 0;

        for (int i = 0; i < MEM; i++) mem[i] = DW'(i * 29 + 11);

        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        w_ready   = 1'b0;
        repeat (3) @(posedge clka);
        #1;
        check_reset("reset");
        chk("wea_const",  ram_wea,  0);
        chk("dina_const", ram_dina, 0);
        rst = 1'b0;
        @(posedge clka); #1;
        check_reset("post_reset");

        run_burst(0, 9, 0, 1'b0);
        run_burst(4, 6, 1, 1'b0);
        run_burst(MEM - 2, 4, 0, 1'b0);
        run_burst(0, 0, 0, 1'b0);
        run_burst(0, 9, 0, 1'b1);

        // Abort a burst with reset after three words have been delivered.
        start     = 1'b1;
        base_addr = '0;
        len       = LW'(9);
        w_ready   = 1'b1;
        @(posedge clka); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && pops < 3; c++) begin
            #1;
            if (w_valid && w_ready) pops++;
            @(posedge clka); #1;
        end
        chk("pre_reset_pops", pops, 3);
        rst = 1'b1;
        @(posedge clka); #1;
        check_reset("rst_mid");
        rst = 1'b0;
        @(posedge clka); #1;
        chk("rst_mid_no_done", done, 0);
        run_burst(0, 2, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
